// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter timer and the sibling up-counters.
// Holds the state encoding and the default counter width.
// No logic; constants and types only.
package down_counter_timer_pkg;

  // Default counter width, shared with the up-counter blocks.
  localparam int DEFAULT_WIDTH = 6;

  // Controller states; 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter: decrements on enabled clocks, pulses tc at zero, then halts or reloads.
// Latency: load visible one edge after the strobe; all outputs registered, no comb in->out path.
// Backpressure: none; en low freezes the count, load always wins over en.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             tc_d;

  // Next-state, next-count and terminal-count decision; load overrides everything.
  always_comb begin
    state_d  = state_q;
    count_d  = count;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      if (load_value == CNT_ZERO) begin
        // Loading zero is an immediate terminal count.
        state_d = ST_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // en is ignored; count holds.
        end
        ST_RUN: begin
          if (en) begin
            if (count == CNT_ZERO) begin
              // Only reachable with auto-reload: the one visible zero cycle ends here.
              count_d = reload_q;
            end else if (count == CNT_ONE) begin
              count_d = CNT_ZERO;
              tc_d    = 1'b1;
              if (!AUTO_RELOAD) begin
                state_d = ST_DONE;
              end
            end else begin
              count_d = count - CNT_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counter, reload value and tc pulse registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= ST_IDLE;
      count    <= '0;
      reload_q <= '0;
      tc       <= 1'b0;
    end else begin
      state_q  <= state_d;
      count    <= count_d;
      reload_q <= reload_d;
      tc       <= tc_d;
    end
  end

  // Status flags decode straight from the state register, so they stay registered.
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  logic       clock;
  logic       clear_n;
  logic       en;
  logic       load;
  logic [5:0] load_value;
  logic [5:0] count0, count1;
  logic       busy0, busy1, tc0, tc1, done0, done1;

  int errors = 0;
  int checks = 0;

  // Reference model state, index 0 = halting instance, 1 = auto-reload instance.
  int m_cnt [2];
  int m_rel [2];
  bit m_run [2];
  bit m_dn  [2];
  bit m_tc  [2];

  down_counter_timer #(.WIDTH(6), .AUTO_RELOAD(1'b0)) u_halt (
    .clock(clock), .clear_n(clear_n), .en(en), .load(load), .load_value(load_value),
    .count(count0), .busy(busy0), .tc(tc0), .done(done0)
  );

  down_counter_timer #(.WIDTH(6), .AUTO_RELOAD(1'b1)) u_auto (
    .clock(clock), .clear_n(clear_n), .en(en), .load(load), .load_value(load_value),
    .count(count1), .busy(busy1), .tc(tc1), .done(done1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 0; m_dn[i] = 0; m_tc[i] = 0;
    end
  endtask

  // Behaviour from the rules: a loaded count runs down over enabled cycles,
  // zero raises tc; halting instance stops, auto instance restarts from the last load.
  task automatic model_step(input bit ld, input int lv, input bit e);
    for (int i = 0; i < 2; i++) begin
      m_tc[i] = 0;
      if (ld) begin
        m_cnt[i] = lv;
        m_rel[i] = lv;
        m_run[i] = (lv != 0);
        m_dn[i]  = (lv == 0);
        m_tc[i]  = (lv == 0);
      end else if (m_run[i] && e) begin
        if (m_cnt[i] == 0) begin
          m_cnt[i] = m_rel[i];
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin
            m_tc[i] = 1;
            if (i == 0) begin
              m_run[i] = 0;
              m_dn[i]  = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string phase);
    check({phase, " halt.count"}, 8'(count0), 8'(m_cnt[0]));
    check({phase, " halt.busy"},  8'(busy0),  8'(m_run[0]));
    check({phase, " halt.tc"},    8'(tc0),    8'(m_tc[0]));
    check({phase, " halt.done"},  8'(done0),  8'(m_dn[0]));
    check({phase, " auto.count"}, 8'(count1), 8'(m_cnt[1]));
    check({phase, " auto.busy"},  8'(busy1),  8'(m_run[1]));
    check({phase, " auto.tc"},    8'(tc1),    8'(m_tc[1]));
    check({phase, " auto.done"},  8'(done1),  8'(m_dn[1]));
  endtask

  // One clock: drive inputs away from the edge, step the model on the edge, check after it.
  task automatic cycle(input string phase, input bit ld, input logic [5:0] lv, input bit e);
    load       = ld;
    load_value = lv;
    en         = e;
    @(posedge clock);
    model_step(ld, int'(lv), e);
    #1;
    compare_all(phase);
  endtask

  initial begin
    int tc_seen;
    int tc_at;
    int en_cycles;

    en = 1'b0; load = 1'b0; load_value = '0;
    clear_n = 1'b0;
    model_reset();
    #30;
    compare_all("reset");
    #2 clear_n = 1'b1;

    // IDLE ignores en.
    for (int k = 0; k < 4; k++) cycle("idle_en", 1'b0, 6'd0, 1'b1);

    // Basic countdown from 5.
    cycle("load5", 1'b1, 6'd5, 1'b1);
    check("load5 count", 8'(count0), 8'd5);
    for (int k = 1; k <= 5; k++) begin
      cycle("count5", 1'b0, 6'd0, 1'b1);
      check("count5 seq", 8'(count0), 8'(5 - k));
    end
    check("count5 tc", 8'(tc0), 8'd1);
    for (int k = 0; k < 20; k++) cycle("done_hold", 1'b0, 6'd0, 1'b1);
    check("done_hold done", 8'(done0), 8'd1);

    // Enable gating: load 10, en alternating, zero reached on the 20th cycle.
    cycle("load10", 1'b1, 6'd10, 1'b0);
    tc_seen = 0; tc_at = -1;
    for (int k = 1; k <= 24; k++) begin
      cycle("gate", 1'b0, 6'd0, (k % 2) == 1 ? 1'b0 : 1'b1);
      if (tc0) begin
        tc_seen++;
        if (tc_at < 0) tc_at = k;
      end
    end
    check("gate tc_count", 8'(tc_seen), 8'd1);
    check("gate tc_cycle", 8'(tc_at), 8'd20);

    // Load priority over en.
    cycle("load3_en", 1'b1, 6'd3, 1'b1);
    check("load3 no_dec", 8'(count0), 8'd3);
    cycle("load3_run", 1'b0, 6'd0, 1'b1);

    // Load zero: immediate DONE with a tc pulse.
    cycle("load0", 1'b1, 6'd0, 1'b1);
    check("load0 tc", 8'(tc0), 8'd1);
    check("load0 done", 8'(done0), 8'd1);
    cycle("load0_after", 1'b0, 6'd0, 1'b1);
    check("load0 tc_once", 8'(tc0), 8'd0);

    // Full-scale load: 63 enabled cycles to tc.
    cycle("load63", 1'b1, 6'd63, 1'b1);
    tc_at = -1; en_cycles = 0;
    for (int k = 1; k <= 70; k++) begin
      cycle("run63", 1'b0, 6'd0, 1'b1);
      en_cycles++;
      if (tc0 && tc_at < 0) tc_at = en_cycles;
    end
    check("load63 tc_cycle", 8'(tc_at), 8'd63);

    // Auto-reload: load 4, 30 enabled cycles -> tc every 5 cycles.
    cycle("load4", 1'b1, 6'd4, 1'b1);
    tc_seen = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle("auto4", 1'b0, 6'd0, 1'b1);
      if (tc1) tc_seen++;
      if (k == 5) check("auto4 reload", 8'(count1), 8'd4);
    end
    check("auto4 tc_count", 8'(tc_seen), 8'd6);
    check("auto4 busy", 8'(busy1), 8'd1);

    // Reset mid-operation, asserted between edges.
    cycle("load40", 1'b1, 6'd40, 1'b1);
    for (int k = 0; k < 10; k++) cycle("run40", 1'b0, 6'd0, 1'b1);
    #2 clear_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_clr");
    #1 clear_n = 1'b1;
    cycle("post_clr", 1'b0, 6'd0, 1'b1);
    cycle("load2", 1'b1, 6'd2, 1'b1);
    cycle("run2", 1'b0, 6'd0, 1'b1);
    cycle("run2", 1'b0, 6'd0, 1'b1);
    check("load2 tc", 8'(tc0), 8'd1);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic       r_ld;
      logic [5:0] r_lv;
      logic       r_en;
      r_ld = ($urandom_range(0, 9) == 0);
      r_lv = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
      r_en = ($urandom_range(0, 3) != 0);
      cycle("random", r_ld, r_lv, r_en);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
